// File: rtl/score_pkg.sv
// Shared types and helpers for the BCD score accumulator.
//   bcd_t / bcd4_t  : one BCD digit / four BCD digits (index 0 = least significant)
//   score_state_t   : add-sequencer states
//   points_for()    : rows-cleared -> points (0 means "not a legal count")
//   bcd_greater()   : magnitude compare of two 4-digit BCD values, top digit first
package score_pkg;

    typedef logic [3:0] bcd_t;
    typedef bcd_t [3:0] bcd4_t;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ADD0    = 3'd1,
        ST_ADD1    = 3'd2,
        ST_ADD2    = 3'd3,
        ST_ADD3    = 3'd4,
        ST_COMMIT  = 3'd5,
        ST_HISCORE = 3'd6
    } score_state_t;

    localparam bcd4_t SCORE_MAX = 16'h9999;

    function automatic bcd_t points_for(input logic [2:0] count);
        bcd_t pts;
        case (count)
            3'd1:    pts = 4'd1;
            3'd2:    pts = 4'd3;
            3'd3:    pts = 4'd5;
            3'd4:    pts = 4'd8;
            default: pts = 4'd0;
        endcase
        return pts;
    endfunction

    function automatic logic bcd_greater(input bcd4_t a, input bcd4_t b);
        logic decided;
        logic gt;
        decided = 1'b0;
        gt      = 1'b0;
        for (int i = 3; i >= 0; i--) begin
            if (!decided && (a[i] != b[i])) begin
                decided = 1'b1;
                gt      = (a[i] > b[i]);
            end else begin
                decided = decided;
            end
        end
        return gt;
    endfunction

endpackage

// File: rtl/score_bcd_accumulator_if.sv
// Bus between game logic / display driver and the score accumulator.
//   tick, game_over, clear_valid, clear_count : towards the accumulator
//   digit0..digit3, busy, overflow            : from the accumulator
// master = environment side, slave = accumulator side.
interface score_bcd_accumulator_if;
    logic       tick;
    logic       game_over;
    logic       clear_valid;
    logic [2:0] clear_count;
    logic [3:0] digit0;
    logic [3:0] digit1;
    logic [3:0] digit2;
    logic [3:0] digit3;
    logic       busy;
    logic       overflow;

    modport master (
        output tick, game_over, clear_valid, clear_count,
        input  digit0, digit1, digit2, digit3, busy, overflow
    );

    modport slave (
        input  tick, game_over, clear_valid, clear_count,
        output digit0, digit1, digit2, digit3, busy, overflow
    );
endinterface

// File: rtl/bcd_digit_add.sv
// Single-digit BCD adder: sum/cout = a + b + cin with +6 decimal correction.
//   a, b : BCD digit operands (0..9)
//   cin  : carry in
//   sum  : corrected BCD digit
//   cout : decimal carry out
module bcd_digit_add
    import score_pkg::*;
(
    input  bcd_t a,
    input  bcd_t b,
    input  logic cin,
    output bcd_t sum,
    output logic cout
);
    logic [4:0] raw_s;

    // Binary add then fold results above 9 back into BCD range.
    always_comb begin
        raw_s = {1'b0, a} + {1'b0, b} + {4'b0000, cin};
        sum   = raw_s[3:0];
        cout  = 1'b0;
        if (raw_s > 5'd9) begin
            sum  = 4'(raw_s + 5'd6);
            cout = 1'b1;
        end else begin
            sum  = raw_s[3:0];
            cout = 1'b0;
        end
    end
endmodule

// File: rtl/score_bcd_accumulator.sv
// 4-digit BCD score / high-score keeper feeding a seven-segment driver.
//   clk, reset : system clock, synchronous active-high reset
//   bus        : slave side of score_bcd_accumulator_if (events in, digits/status out)
// Row-clear points are added one digit per cycle through a shared BCD adder;
// one event arriving during an add is parked in a pending slot, a second is
// dropped and flagged in the sticky overflow bit.
module score_bcd_accumulator
    import score_pkg::*;
#(
    parameter int BLINK_TICKS = 2,
    parameter int MAX_DIGIT   = 9
) (
    input logic                       clk,
    input logic                       reset,
    score_bcd_accumulator_if.slave    bus
);
    localparam int    CNT_W     = (BLINK_TICKS > 1) ? $clog2(BLINK_TICKS) : 1;
    localparam bcd_t  SAT_DIGIT = bcd_t'(MAX_DIGIT);
    // The default build saturates at the package constant.
    localparam bcd4_t SAT_VALUE = (MAX_DIGIT == 9) ? SCORE_MAX : {4{SAT_DIGIT}};

    score_state_t state_r, state_nxt_s;
    bcd4_t        score_r, score_nxt_s, high_r, high_nxt_s, work_r, work_nxt_s, digits_r, digits_nxt_s;
    bcd_t         addend_r, addend_nxt_s;
    logic         carry_r, carry_nxt_s;
    logic         pend_valid_r, pend_valid_nxt_s;
    logic [2:0]   pend_count_r, pend_count_nxt_s;
    logic         overflow_r, overflow_nxt_s;
    logic         go_edge_r, go_edge_nxt_s;
    logic         go_d_r;
    logic         phase_r, phase_nxt_s;
    logic [CNT_W-1:0] tick_cnt_r, tick_cnt_nxt_s;
    logic         busy_r, busy_nxt_s;

    logic         strobe_legal_s, go_rise_s, go_fall_s, live_taken_s;
    logic [1:0]   digit_idx_s;
    bcd_t         add_b_s, add_sum_s;
    logic         add_cin_s, add_cout_s;

    bcd_digit_add u_add (
        .a    (score_r[digit_idx_s]),
        .b    (add_b_s),
        .cin  (add_cin_s),
        .sum  (add_sum_s),
        .cout (add_cout_s)
    );

    // Pick which score digit the shared adder works on and its addend/carry.
    always_comb begin
        digit_idx_s = 2'd0;
        add_b_s     = 4'd0;
        add_cin_s   = carry_r;
        case (state_r)
            ST_ADD0: begin
                digit_idx_s = 2'd0;
                add_b_s     = addend_r;
                add_cin_s   = 1'b0;
            end
            ST_ADD1: digit_idx_s = 2'd1;
            ST_ADD2: digit_idx_s = 2'd2;
            ST_ADD3: digit_idx_s = 2'd3;
            default: digit_idx_s = 2'd0;
        endcase
    end

    // Sequencer next state, event buffering, game-over edges and display select.
    always_comb begin
        state_nxt_s      = state_r;
        score_nxt_s      = score_r;
        high_nxt_s       = high_r;
        work_nxt_s       = work_r;
        addend_nxt_s     = addend_r;
        carry_nxt_s      = carry_r;
        pend_valid_nxt_s = pend_valid_r;
        pend_count_nxt_s = pend_count_r;
        overflow_nxt_s   = overflow_r;
        go_edge_nxt_s    = go_edge_r;
        phase_nxt_s      = phase_r;
        tick_cnt_nxt_s   = tick_cnt_r;

        strobe_legal_s = bus.clear_valid && !bus.game_over && (points_for(bus.clear_count) != 4'd0);
        go_rise_s      = bus.game_over && !go_d_r;
        go_fall_s      = !bus.game_over && go_d_r;
        // A live strobe goes straight to the adder only when idle with nothing parked.
        live_taken_s   = (state_r == ST_IDLE) && !pend_valid_r && strobe_legal_s;

        case (state_r)
            ST_IDLE: begin
                if (pend_valid_r) begin
                    addend_nxt_s     = points_for(pend_count_r);
                    pend_valid_nxt_s = 1'b0;
                    state_nxt_s      = ST_ADD0;
                end else if (strobe_legal_s) begin
                    addend_nxt_s = points_for(bus.clear_count);
                    state_nxt_s  = ST_ADD0;
                end else if (go_edge_r) begin
                    state_nxt_s = ST_HISCORE;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_ADD0, ST_ADD1, ST_ADD2, ST_ADD3: begin
                work_nxt_s[digit_idx_s] = add_sum_s;
                carry_nxt_s             = add_cout_s;
                state_nxt_s             = (state_r == ST_ADD3) ? ST_COMMIT : score_state_t'(state_r + 3'd1);
            end
            ST_COMMIT: begin
                score_nxt_s = carry_r ? SAT_VALUE : work_r;
                state_nxt_s = ST_IDLE;
            end
            ST_HISCORE: begin
                if (bcd_greater(score_r, high_r)) begin
                    high_nxt_s = score_r;
                end else begin
                    high_nxt_s = high_r;
                end
                go_edge_nxt_s = 1'b0;
                state_nxt_s   = ST_IDLE;
            end
            default: state_nxt_s = ST_IDLE;
        endcase

        // Park or drop a strobe that the adder cannot take right now.
        if (strobe_legal_s && !live_taken_s) begin
            if (!pend_valid_nxt_s) begin
                pend_valid_nxt_s = 1'b1;
                pend_count_nxt_s = bus.clear_count;
            end else begin
                overflow_nxt_s = 1'b1;
            end
        end else begin
            overflow_nxt_s = overflow_nxt_s;
        end

        // Game-over edges: rise arms the high-score check and restarts the blink;
        // fall starts a new game, overriding anything committed this cycle.
        if (go_rise_s) begin
            go_edge_nxt_s  = 1'b1;
            phase_nxt_s    = 1'b0;
            tick_cnt_nxt_s = '0;
        end else if (go_fall_s) begin
            score_nxt_s      = '0;
            pend_valid_nxt_s = 1'b0;
            go_edge_nxt_s    = 1'b0;
        end else if (bus.game_over && bus.tick) begin
            if (tick_cnt_r == CNT_W'(BLINK_TICKS - 1)) begin
                tick_cnt_nxt_s = '0;
                phase_nxt_s    = !phase_r;
            end else begin
                tick_cnt_nxt_s = tick_cnt_r + 1'b1;
            end
        end else begin
            tick_cnt_nxt_s = tick_cnt_nxt_s;
        end

        digits_nxt_s = (bus.game_over && phase_r) ? high_r : score_r;
        busy_nxt_s   = pend_valid_nxt_s ||
                       ((state_nxt_s != ST_IDLE) && (state_nxt_s != ST_HISCORE));
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r      <= ST_IDLE;
            score_r      <= '0;
            high_r       <= '0;
            work_r       <= '0;
            addend_r     <= 4'd0;
            carry_r      <= 1'b0;
            pend_valid_r <= 1'b0;
            pend_count_r <= 3'd0;
            overflow_r   <= 1'b0;
            go_edge_r    <= 1'b0;
            go_d_r       <= 1'b0;
            phase_r      <= 1'b0;
            tick_cnt_r   <= '0;
            digits_r     <= '0;
            busy_r       <= 1'b0;
        end else begin
            state_r      <= state_nxt_s;
            score_r      <= score_nxt_s;
            high_r       <= high_nxt_s;
            work_r       <= work_nxt_s;
            addend_r     <= addend_nxt_s;
            carry_r      <= carry_nxt_s;
            pend_valid_r <= pend_valid_nxt_s;
            pend_count_r <= pend_count_nxt_s;
            overflow_r   <= overflow_nxt_s;
            go_edge_r    <= go_edge_nxt_s;
            go_d_r       <= bus.game_over;
            phase_r      <= phase_nxt_s;
            tick_cnt_r   <= tick_cnt_nxt_s;
            digits_r     <= digits_nxt_s;
            busy_r       <= busy_nxt_s;
        end
    end

    assign bus.digit0   = digits_r[0];
    assign bus.digit1   = digits_r[1];
    assign bus.digit2   = digits_r[2];
    assign bus.digit3   = digits_r[3];
    assign bus.busy     = busy_r;
    assign bus.overflow = overflow_r;
endmodule

// File: tb/tb_score_bcd_accumulator.sv
// Directed self-checking bench for score_bcd_accumulator.
module tb_score_bcd_accumulator;
    logic clk;
    logic reset;
    int   n_cmp;
    int   n_err;

    score_bcd_accumulator_if bus_if();

    score_bcd_accumulator #(.BLINK_TICKS(2), .MAX_DIGIT(9)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] disp();
        return {bus_if.digit3, bus_if.digit2, bus_if.digit1, bus_if.digit0};
    endfunction

    task automatic strobe(input logic [2:0] c);
        bus_if.clear_valid = 1'b1;
        bus_if.clear_count = c;
        step();
        bus_if.clear_valid = 1'b0;
        bus_if.clear_count = 3'd0;
    endtask

    task automatic wait_idle();
        int cnt;
        cnt = 0;
        while (bus_if.busy && cnt < 200) begin
            step();
            cnt++;
        end
        check("busy_timeout", {15'd0, (cnt >= 200)}, 16'd0);
    endtask

    task automatic add(input logic [2:0] c);
        strobe(c);
        wait_idle();
    endtask

    task automatic reset_dut();
        reset = 1'b1;
        step();
        reset = 1'b0;
        step();
    endtask

    task automatic two_ticks();
        for (int i = 0; i < 2; i++) begin
            bus_if.tick = 1'b1;
            step();
            bus_if.tick = 1'b0;
            step();
        end
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        reset = 1'b1;
        bus_if.tick        = 1'b0;
        bus_if.game_over   = 1'b0;
        bus_if.clear_valid = 1'b0;
        bus_if.clear_count = 3'd0;
        step();
        step();
        reset = 1'b0;
        step();
        check("reset_digits", disp(), 16'h0000);
        check("reset_busy", {15'd0, bus_if.busy}, 16'd0);
        check("reset_ovf", {15'd0, bus_if.overflow}, 16'd0);

        // Single count=4 event: busy for 5 cycles, result 6 cycles after accept.
        strobe(3'd4);
        check("busy_c0", {15'd0, bus_if.busy}, 16'd1);
        for (int i = 1; i < 5; i++) begin
            step();
            check("busy_c1_4", {15'd0, bus_if.busy}, 16'd1);
        end
        step();
        check("busy_c5", {15'd0, bus_if.busy}, 16'd0);
        check("digits_c5", disp(), 16'h0000);
        step();
        check("digits_c6", disp(), 16'h0008);

        // Second event buffered while the first add runs.
        strobe(3'd2);
        step();
        step();
        strobe(3'd3);
        check("buffered_busy", {15'd0, bus_if.busy}, 16'd1);
        wait_idle();
        step();
        check("score_0016", disp(), 16'h0016);
        check("ovf_after_buffer", {15'd0, bus_if.overflow}, 16'd0);

        // Three back-to-back strobes: accept, park, drop.
        reset_dut();
        strobe(3'd1);
        strobe(3'd1);
        check("ovf_before_drop", {15'd0, bus_if.overflow}, 16'd0);
        strobe(3'd1);
        check("ovf_after_drop", {15'd0, bus_if.overflow}, 16'd1);
        wait_idle();
        step();
        check("score_0002", disp(), 16'h0002);

        // Illegal counts are ignored.
        bus_if.clear_valid = 1'b1;
        bus_if.clear_count = 3'd0;
        step();
        check("illegal0_busy", {15'd0, bus_if.busy}, 16'd0);
        bus_if.clear_count = 3'd5;
        step();
        bus_if.clear_count = 3'd7;
        step();
        bus_if.clear_valid = 1'b0;
        bus_if.clear_count = 3'd0;
        check("illegal57_busy", {15'd0, bus_if.busy}, 16'd0);
        step();
        check("illegal_score", disp(), 16'h0002);

        // Reset while in ADD2 discards the partial add and sticky flag.
        strobe(3'd4);
        step();
        step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("midreset_digits", disp(), 16'h0000);
        check("midreset_busy", {15'd0, bus_if.busy}, 16'd0);
        check("midreset_ovf", {15'd0, bus_if.overflow}, 16'd0);
        step();
        step();
        check("midreset_stays0", disp(), 16'h0000);
        add(3'd1);
        step();
        check("after_reset_0001", disp(), 16'h0001);

        // Climb to 9997, then saturate.
        reset_dut();
        for (int i = 0; i < 1249; i++) add(3'd4);
        add(3'd3);
        step();
        check("score_9997", disp(), 16'h9997);
        add(3'd3);
        step();
        check("saturate_9999", disp(), 16'h9999);
        check("saturate_ovf", {15'd0, bus_if.overflow}, 16'd0);

        // Game over: high-score capture, blinking, new game.
        reset_dut();
        for (int i = 0; i < 4; i++) add(3'd4);
        add(3'd2);
        step();
        check("score_0035", disp(), 16'h0035);
        bus_if.game_over = 1'b1;
        repeat (4) step();
        two_ticks();
        check("go1_high", disp(), 16'h0035);
        bus_if.game_over = 1'b0;
        step();
        step();
        check("newgame1_score", disp(), 16'h0000);

        for (int i = 0; i < 4; i++) add(3'd4);
        add(3'd3);
        add(3'd3);
        step();
        check("score_0042", disp(), 16'h0042);
        bus_if.game_over = 1'b1;
        repeat (4) step();
        check("go2_phase0", disp(), 16'h0042);
        bus_if.clear_valid = 1'b1;
        bus_if.clear_count = 3'd4;
        step();
        bus_if.clear_valid = 1'b0;
        bus_if.clear_count = 3'd0;
        check("go_strobe_busy", {15'd0, bus_if.busy}, 16'd0);
        step();
        check("go_strobe_score", disp(), 16'h0042);
        two_ticks();
        check("go2_phase1", disp(), 16'h0042);
        two_ticks();
        check("go2_phase0b", disp(), 16'h0042);
        bus_if.game_over = 1'b0;
        step();
        step();
        check("newgame2_score", disp(), 16'h0000);

        bus_if.game_over = 1'b1;
        repeat (4) step();
        check("go3_phase0", disp(), 16'h0000);
        two_ticks();
        check("go3_high_kept", disp(), 16'h0042);
        two_ticks();
        check("go3_phase0b", disp(), 16'h0000);
        bus_if.game_over = 1'b0;
        step();
        step();
        check("final_ovf", {15'd0, bus_if.overflow}, 16'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
